// File: rtl/pc_unit.sv
// pc_unit: owned program-counter register with next-PC selection for the
// fetch stage. Handles sequential flow, j/jal, beq/bne, jr/jalr, stall hold,
// an optional one-instruction branch delay slot and exception entry/return
// through an EPC register and an EXL mode flag.
module pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
   parameter int          DELAY_SLOT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [2:0]  sel,
   input  logic        a_b_equal,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] rs_val,
   input  logic        exc_req,
   input  logic        eret,
   output logic [31:0] pc,
   output logic [31:0] npc,
   output logic [31:0] epc,
   output logic        exl,
   output logic        adel
);

   localparam logic [2:0] SEL_J   = 3'b001;
   localparam logic [2:0] SEL_BEQ = 3'b010;
   localparam logic [2:0] SEL_BNE = 3'b011;
   localparam logic [2:0] SEL_JR  = 3'b100;

   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic        exl_q, exl_d;
   logic        pendValid_q, pendValid_d;
   logic [31:0] pendTgt_q, pendTgt_d;

   logic [31:0] seqPc;
   logic [31:0] branchTgt;
   logic [31:0] jumpTgt;
   logic [31:0] redirTgt;
   logic        redirTaken;
   logic        adelInt;
   logic        excAny;

   // Candidate targets and the taken decision for the instruction at pc.
   always_comb begin
      seqPc      = pc_q + 32'd4;
      branchTgt  = seqPc + {{14{imm16[15]}}, imm16, 2'b00};
      jumpTgt    = {pc_q[31:28], imm26, 2'b00};
      adelInt    = (sel == SEL_JR) && (rs_val[1:0] != 2'b00);
      excAny     = exc_req | adelInt;
      redirTaken = 1'b0;
      redirTgt   = seqPc;
      case (sel)
         SEL_J: begin
            redirTaken = 1'b1;
            redirTgt   = jumpTgt;
         end
         SEL_BEQ: begin
            redirTaken = a_b_equal;
            redirTgt   = branchTgt;
         end
         SEL_BNE: begin
            redirTaken = ~a_b_equal;
            redirTgt   = branchTgt;
         end
         SEL_JR: begin
            redirTaken = ~adelInt;
            redirTgt   = rs_val;
         end
         default: begin
            redirTaken = 1'b0;
            redirTgt   = seqPc;
         end
      endcase
   end

   // Next-state selection: exception entry, exception return, pending delay-slot
   // target, taken redirect, then sequential flow.
   always_comb begin
      pc_d        = seqPc;
      epc_d       = epc_q;
      exl_d       = exl_q;
      pendValid_d = 1'b0;
      pendTgt_d   = pendTgt_q;
      if (excAny && !exl_q) begin
         pc_d  = EXC_VEC;
         epc_d = pc_q;
         exl_d = 1'b1;
      end else if (eret && exl_q) begin
         pc_d  = epc_q;
         exl_d = 1'b0;
      end else if ((DELAY_SLOT != 0) && pendValid_q) begin
         pc_d = pendTgt_q;
      end else if (redirTaken) begin
         if (DELAY_SLOT == 0) begin
            pc_d = redirTgt;
         end else begin
            pendValid_d = 1'b1;
            pendTgt_d   = redirTgt;
         end
      end
   end

   // State registers: reset beats everything, stall freezes all state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         epc_q       <= 32'h0000_0000;
         exl_q       <= 1'b0;
         pendValid_q <= 1'b0;
         pendTgt_q   <= 32'h0000_0000;
      end else if (!stall) begin
         pc_q        <= pc_d;
         epc_q       <= epc_d;
         exl_q       <= exl_d;
         pendValid_q <= pendValid_d;
         pendTgt_q   <= pendTgt_d;
      end
   end

   assign pc   = pc_q;
   assign npc  = pc_d;
   assign epc  = epc_q;
   assign exl  = exl_q;
   assign adel = adelInt;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit. One instance runs
// without a delay slot (u0), one with a delay slot (u1); both share inputs
// and each phase checks only the instance it exercises.
module tb_pc_unit;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic [2:0]  sel;
   logic        aBEqual;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [31:0] rsVal;
   logic        excReq;
   logic        eret;

   logic [31:0] pc0, npc0, epc0, pc1, npc1, epc1;
   logic        exl0, adel0, exl1, adel1;

   int testsRun = 0;
   int testsFailed = 0;

   pc_unit #(.RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .DELAY_SLOT(0)) u0 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .sel(sel), .a_b_equal(aBEqual),
      .imm16(imm16), .imm26(imm26), .rs_val(rsVal), .exc_req(excReq), .eret(eret),
      .pc(pc0), .npc(npc0), .epc(epc0), .exl(exl0), .adel(adel0)
   );

   pc_unit #(.RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .DELAY_SLOT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .stall(stall), .sel(sel), .a_b_equal(aBEqual),
      .imm16(imm16), .imm26(imm26), .rs_val(rsVal), .exc_req(excReq), .eret(eret),
      .pc(pc1), .npc(npc1), .epc(epc1), .exl(exl1), .adel(adel1)
   );

   // Free-running clock, posedges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic [2:0] s, input logic ab, input logic [15:0] i16,
                                input logic [25:0] i26, input logic [31:0] rs,
                                input logic ex, input logic er);
      sel     = s;
      aBEqual = ab;
      imm16   = i16;
      imm26   = i26;
      rsVal   = rs;
      excReq  = ex;
      eret    = er;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      checkOutput("rst_pc0", pc0, 32'h0000_3000);
      checkOutput("rst_epc0", epc0, 32'h0);
      checkOutput("rst_exl0", {31'b0, exl0}, 32'h0);
      checkOutput("rst_pc1", pc1, 32'h0000_3000);

      // Sequential flow and stall hold
      tick(); checkOutput("seq1", pc0, 32'h0000_3004);
      tick(); checkOutput("seq2", pc0, 32'h0000_3008);
      tick(); checkOutput("seq3", pc0, 32'h0000_300C);
      stall = 1'b1;
      #1 checkOutput("stall_npc", npc0, 32'h0000_3010);
      tick(); tick();
      checkOutput("stall_hold", pc0, 32'h0000_300C);
      stall = 1'b0;
      tick(); checkOutput("seq4", pc0, 32'h0000_3010);

      // Branches without delay slot
      applyStimulus(3'b010, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("beq_t_npc", npc0, 32'h0000_3010);
      tick(); checkOutput("beq_taken", pc0, 32'h0000_3010);
      applyStimulus(3'b010, 1'b0, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("beq_not", pc0, 32'h0000_3014);
      applyStimulus(3'b011, 1'b1, 16'h0004, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("bne_not", pc0, 32'h0000_3018);
      applyStimulus(3'b011, 1'b0, 16'h0004, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("bne_taken", pc0, 32'h0000_302C);

      // Jumps
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h3000_0000, 1'b0, 1'b0);
      tick(); checkOutput("jr_hi", pc0, 32'h3000_0000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000100, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("j_region", pc0, 32'h3000_0400);
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_3100, 1'b0, 1'b0);
      tick(); checkOutput("jr_3100", pc0, 32'h0000_3100);
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_3020, 1'b0, 1'b0);
      tick(); checkOutput("jr_3020", pc0, 32'h0000_3020);

      // Misaligned jr -> exception entry
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_3102, 1'b0, 1'b0);
      checkOutput("adel_hi", {31'b0, adel0}, 32'h1);
      checkOutput("adel_npc", npc0, 32'h0000_4180);
      tick();
      checkOutput("exc_pc", pc0, 32'h0000_4180);
      checkOutput("exc_epc", epc0, 32'h0000_3020);
      checkOutput("exc_exl", {31'b0, exl0}, 32'h1);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      tick();
      checkOutput("nest_pc", pc0, 32'h0000_4184);
      checkOutput("nest_epc", epc0, 32'h0000_3020);
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h0000_4201, 1'b0, 1'b0);
      tick();
      checkOutput("adel_inexl_pc", pc0, 32'h0000_4188);
      checkOutput("adel_inexl_exl", {31'b0, exl0}, 32'h1);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
      tick();
      checkOutput("eret_pc", pc0, 32'h0000_3020);
      checkOutput("eret_exl", {31'b0, exl0}, 32'h0);
      tick();
      checkOutput("eret_ign_pc", pc0, 32'h0000_3024);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
      tick();
      checkOutput("both_exl0_pc", pc0, 32'h0000_4180);
      checkOutput("both_exl0_epc", epc0, 32'h0000_3024);
      tick();
      checkOutput("both_exl1_pc", pc0, 32'h0000_3024);
      checkOutput("both_exl1_exl", {31'b0, exl0}, 32'h0);

      // Wrap-around
      applyStimulus(3'b100, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("jr_zero", pc0, 32'h0);
      applyStimulus(3'b010, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("neg_wrap", pc0, 32'hFFFF_FFFC);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("seq_wrap", pc0, 32'h0);

      // Delay-slot instance
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checkOutput("ds_rst_pc", pc1, 32'h0000_3000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000800, 32'h0, 1'b0, 1'b0);
      checkOutput("ds_j_npc", npc1, 32'h0000_3004);
      tick(); checkOutput("ds_slot", pc1, 32'h0000_3004);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("ds_pend_npc", npc1, 32'h0000_2000);
      tick(); checkOutput("ds_tgt", pc1, 32'h0000_2000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000C00, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_slot2", pc1, 32'h0000_2004);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000900, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_slot_redir_ign", pc1, 32'h0000_3000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000800, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_slot3", pc1, 32'h0000_3004);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      stall = 1'b1;
      tick(); checkOutput("ds_stall_hold", pc1, 32'h0000_3004);
      stall = 1'b0;
      tick(); checkOutput("ds_stall_tgt", pc1, 32'h0000_2000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000C00, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_back", pc1, 32'h0000_3000);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000800, 32'h0, 1'b0, 1'b0);
      tick();
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0);
      tick();
      checkOutput("ds_exc_pc", pc1, 32'h0000_4180);
      checkOutput("ds_exc_epc", epc1, 32'h0000_3004);
      checkOutput("ds_exc_exl", {31'b0, exl1}, 32'h1);
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_pend_drop", pc1, 32'h0000_4184);
      applyStimulus(3'b001, 1'b0, 16'h0, 26'h0000800, 32'h0, 1'b0, 1'b0);
      tick(); checkOutput("ds_pend_again", pc1, 32'h0000_4188);

      // Reset with pending redirect and stall both asserted
      applyStimulus(3'b000, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      stall = 1'b1;
      tick();
      checkOutput("ds_rst_pc2", pc1, 32'h0000_3000);
      checkOutput("ds_rst_exl", {31'b0, exl1}, 32'h0);
      checkOutput("ds_rst_epc", epc1, 32'h0);
      rst_n = 1'b1;
      stall = 1'b0;
      tick(); checkOutput("ds_rst_nopend", pc1, 32'h0000_3004);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
